// File: rtl/vgachargen_pkg.sv
// Shared vgachargen types and widths: memory port widths, APB decode regions,
// slave FSM states and the glyph-row word select/merge helpers.
package vgachargen_pkg;

  localparam int CH_MAP_ADDR_WIDTH  = 12;
  localparam int CH_MAP_DATA_WIDTH  = 8;
  localparam int COL_MAP_ADDR_WIDTH = 12;
  localparam int COL_MAP_DATA_WIDTH = 8;
  localparam int CH_T_ADDR_WIDTH    = 7;
  localparam int CH_T_DATA_WIDTH    = 128;
  localparam int APB_DATA_WIDTH     = 32;
  localparam int CH_T_WORDS         = CH_T_DATA_WIDTH / APB_DATA_WIDTH;
  localparam int CH_T_SEL_WIDTH     = $clog2(CH_T_WORDS);

  typedef enum logic [1:0] {
    REG_CH_MAP  = 2'b00,
    REG_COL_MAP = 2'b01,
    REG_CH_T    = 2'b10,
    REG_RSVD    = 2'b11
  } region_e;

  typedef enum logic [3:0] {
    IDLE,
    MAP_WR,
    MAP_RD,
    MAP_RESP,
    CHT_RD,
    CHT_LATCH,
    CHT_WR,
    CHT_RESP,
    ERR
  } state_e;

  // Word 0 of a glyph row occupies bits [31:0].
  function automatic logic [CH_T_DATA_WIDTH-1:0] merge_word(
    input logic [CH_T_DATA_WIDTH-1:0] row,
    input logic [CH_T_SEL_WIDTH-1:0]  sel,
    input logic [APB_DATA_WIDTH-1:0]  data
  );
    logic [CH_T_DATA_WIDTH-1:0] res;
    res = row;
    res[sel*APB_DATA_WIDTH +: APB_DATA_WIDTH] = data;
    return res;
  endfunction

  function automatic logic [APB_DATA_WIDTH-1:0] select_word(
    input logic [CH_T_DATA_WIDTH-1:0] row,
    input logic [CH_T_SEL_WIDTH-1:0]  sel
  );
    return row[sel*APB_DATA_WIDTH +: APB_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/apb_vgachargen_decode.sv
// Combinational APB byte-address decoder: region, map index, glyph entry/word
// and the out-of-range flag.
module apb_vgachargen_decode
  import vgachargen_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int MAP_DEPTH      = 2400
) (
  input  logic [APB_ADDR_WIDTH-1:0]    paddr_i,
  output region_e                      region_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0] idx_o,
  output logic [CH_T_ADDR_WIDTH-1:0]   entry_o,
  output logic [CH_T_SEL_WIDTH-1:0]    word_o,
  output logic                         oor_o
);

  localparam logic [CH_MAP_ADDR_WIDTH-1:0] MAP_LIMIT = CH_MAP_ADDR_WIDTH'(MAP_DEPTH);

  always_comb begin
    region_o = region_e'(paddr_i[15:14]);
    idx_o    = paddr_i[13:2];
    entry_o  = paddr_i[10:4];
    word_o   = paddr_i[3:2];
    oor_o    = (paddr_i[1:0] != 2'b00);
    case (region_o)
      REG_CH_MAP, REG_COL_MAP: if (idx_o >= MAP_LIMIT) oor_o = 1'b1;
      REG_CH_T:                if (paddr_i[13:11] != 3'b000) oor_o = 1'b1;
      default:                 oor_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/apb_vgachargen_slave.sv
// APB3 CPU-side port for the vgachargen ch_map, col_map and glyph memories.
// Define APB_VGACHARGEN_SLVERR_EN to report out-of-range accesses on pslverr_o.
module apb_vgachargen_slave
  import vgachargen_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int MAP_DEPTH      = 2400
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]     paddr_i,
  input  logic [31:0]                   pwdata_i,
  output logic [31:0]                   prdata_o,
  output logic                          pready_o,
  output logic                          pslverr_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_wdata_o,
  output logic                          ch_map_wen_o,
  input  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_rdata_i,
  output logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
  output logic [COL_MAP_DATA_WIDTH-1:0] col_map_wdata_o,
  output logic                          col_map_wen_o,
  input  logic [COL_MAP_DATA_WIDTH-1:0] col_map_rdata_i,
  output logic [CH_T_ADDR_WIDTH-1:0]    ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_wdata_o,
  output logic                          ch_t_rw_wen_o,
  input  logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_rdata_i
);

  region_e                      dec_region;
  logic [CH_MAP_ADDR_WIDTH-1:0] dec_idx;
  logic [CH_T_ADDR_WIDTH-1:0]   dec_entry;
  logic [CH_T_SEL_WIDTH-1:0]    dec_word;
  logic                         dec_oor;

  state_e                       state_q, state_d;
  region_e                      region_q, region_d;
  logic                         write_q, write_d;
  logic [CH_MAP_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CH_T_ADDR_WIDTH-1:0]   entry_q, entry_d;
  logic [CH_T_SEL_WIDTH-1:0]    word_q, word_d;
  logic [31:0]                  wdata_q, wdata_d;
  logic [CH_T_DATA_WIDTH-1:0]   line_q, line_d;

  logic [31:0] prdata_c;
  logic        pready_c;
  logic        pslverr_c;
  logic        ch_map_wen_c;
  logic        col_map_wen_c;
  logic        ch_t_wen_c;

  apb_vgachargen_decode #(
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .MAP_DEPTH      (MAP_DEPTH)
  ) u_decode (
    .paddr_i  (paddr_i),
    .region_o (dec_region),
    .idx_o    (dec_idx),
    .entry_o  (dec_entry),
    .word_o   (dec_word),
    .oor_o    (dec_oor)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      region_q <= REG_CH_MAP;
      write_q  <= 1'b0;
      idx_q    <= '0;
      entry_q  <= '0;
      word_q   <= '0;
      wdata_q  <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      write_q  <= write_d;
      idx_q    <= idx_d;
      entry_q  <= entry_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      line_q   <= line_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    region_d      = region_q;
    write_d       = write_q;
    idx_d         = idx_q;
    entry_d       = entry_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    line_d        = line_q;
    prdata_c      = '0;
    pready_c      = 1'b0;
    pslverr_c     = 1'b0;
    ch_map_wen_c  = 1'b0;
    col_map_wen_c = 1'b0;
    ch_t_wen_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          region_d = dec_region;
          write_d  = pwrite_i;
          idx_d    = dec_idx;
          entry_d  = dec_entry;
          word_d   = dec_word;
          wdata_d  = pwdata_i;
          if (dec_oor)                   state_d = ERR;
          else if (dec_region == REG_CH_T) state_d = CHT_RD;
          else if (pwrite_i)             state_d = MAP_WR;
          else                           state_d = MAP_RD;
        end
      end
      MAP_WR: begin
        pready_c      = 1'b1;
        ch_map_wen_c  = (region_q == REG_CH_MAP);
        col_map_wen_c = (region_q == REG_COL_MAP);
        state_d       = IDLE;
      end
      MAP_RD: state_d = MAP_RESP;
      MAP_RESP: begin
        pready_c = 1'b1;
        if (region_q == REG_CH_MAP)
          prdata_c = {{(32-CH_MAP_DATA_WIDTH){1'b0}}, ch_map_rdata_i};
        else
          prdata_c = {{(32-COL_MAP_DATA_WIDTH){1'b0}}, col_map_rdata_i};
        state_d = IDLE;
      end
      CHT_RD: state_d = CHT_LATCH;
      CHT_LATCH: begin
        line_d  = ch_t_rw_rdata_i;
        state_d = write_q ? CHT_WR : CHT_RESP;
      end
      CHT_WR: begin
        pready_c   = 1'b1;
        ch_t_wen_c = 1'b1;
        state_d    = IDLE;
      end
      CHT_RESP: begin
        pready_c = 1'b1;
        prdata_c = select_word(line_q, word_q);
        state_d  = IDLE;
      end
      ERR: begin
        pready_c = 1'b1;
`ifdef APB_VGACHARGEN_SLVERR_EN
        pslverr_c = 1'b1;
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A master that drops psel mid-transfer abandons it: no response, no new write.
    if (state_q != IDLE && !psel_i) begin
      state_d       = IDLE;
      line_d        = line_q;
      prdata_c      = '0;
      pready_c      = 1'b0;
      pslverr_c     = 1'b0;
      ch_map_wen_c  = 1'b0;
      col_map_wen_c = 1'b0;
      ch_t_wen_c    = 1'b0;
    end
  end

  assign prdata_o        = prdata_c;
  assign pready_o        = pready_c;
  assign pslverr_o       = pslverr_c;
  assign ch_map_addr_o   = idx_q;
  assign ch_map_wdata_o  = wdata_q[CH_MAP_DATA_WIDTH-1:0];
  assign ch_map_wen_o    = ch_map_wen_c;
  assign col_map_addr_o  = idx_q;
  assign col_map_wdata_o = wdata_q[COL_MAP_DATA_WIDTH-1:0];
  assign col_map_wen_o   = col_map_wen_c;
  assign ch_t_rw_addr_o  = entry_q;
  assign ch_t_rw_wdata_o = merge_word(line_q, word_q, wdata_q);
  assign ch_t_rw_wen_o   = ch_t_wen_c;

endmodule

// File: tb/tb_apb_vgachargen_slave.sv
// Scoreboard bench for apb_vgachargen_slave with behavioural 1-cycle-latency
// memories; expected responses are queued at issue and checked on pready.
module tb_apb_vgachargen_slave;

  logic         clk = 1'b0;
  logic         arst;
  logic         psel, penable, pwrite;
  logic [15:0]  paddr;
  logic [31:0]  pwdata;
  logic [31:0]  prdata;
  logic         pready, pslverr;
  logic [11:0]  ch_map_addr, col_map_addr;
  logic [7:0]   ch_map_wdata, col_map_wdata, ch_map_rdata, col_map_rdata;
  logic         ch_map_wen, col_map_wen, ch_t_wen;
  logic [6:0]   ch_t_addr;
  logic [127:0] ch_t_wdata, ch_t_rdata;

  logic [7:0]   ch_map_mem  [4096];
  logic [7:0]   col_map_mem [4096];
  logic [127:0] ch_t_mem    [128];

  typedef struct {
    logic [31:0]  rdata;
    logic         err;
    int           lat;
    int           nwen;
    int           kind;
    logic [11:0]  waddr;
    logic [127:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat_cnt = 0;
  int   wen_cnt = 0;
  int   wen_kind = 0;
  logic [11:0]  wen_addr = '0;
  logic [127:0] wen_data = '0;

`ifdef APB_VGACHARGEN_SLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  apb_vgachargen_slave dut (
    .clk_i           (clk),
    .arst_i          (arst),
    .psel_i          (psel),
    .penable_i       (penable),
    .pwrite_i        (pwrite),
    .paddr_i         (paddr),
    .pwdata_i        (pwdata),
    .prdata_o        (prdata),
    .pready_o        (pready),
    .pslverr_o       (pslverr),
    .ch_map_addr_o   (ch_map_addr),
    .ch_map_wdata_o  (ch_map_wdata),
    .ch_map_wen_o    (ch_map_wen),
    .ch_map_rdata_i  (ch_map_rdata),
    .col_map_addr_o  (col_map_addr),
    .col_map_wdata_o (col_map_wdata),
    .col_map_wen_o   (col_map_wen),
    .col_map_rdata_i (col_map_rdata),
    .ch_t_rw_addr_o  (ch_t_addr),
    .ch_t_rw_wdata_o (ch_t_wdata),
    .ch_t_rw_wen_o   (ch_t_wen),
    .ch_t_rw_rdata_i (ch_t_rdata)
  );

  always #5 clk = ~clk;

  // Read-before-write BRAM models with registered read data
  always @(posedge clk) begin
    ch_map_rdata  <= ch_map_mem[ch_map_addr];
    col_map_rdata <= col_map_mem[col_map_addr];
    ch_t_rdata    <= ch_t_mem[ch_t_addr];
    if (ch_map_wen)  ch_map_mem[ch_map_addr]   = ch_map_wdata;
    if (col_map_wen) col_map_mem[col_map_addr] = col_map_wdata;
    if (ch_t_wen)    ch_t_mem[ch_t_addr]       = ch_t_wdata;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                              input int nwen, input int kind, input logic [11:0] waddr,
                              input logic [127:0] wdata);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.nwen = nwen;
    e.kind = kind; e.waddr = waddr; e.wdata = wdata;
    return e;
  endfunction

  // Monitor: logs write enables and scores every completed transfer
  always @(negedge clk) begin
    exp_t e;
    if (ch_map_wen)  begin wen_cnt++; wen_kind = 1; wen_addr = ch_map_addr;  wen_data = 128'(ch_map_wdata);  end
    if (col_map_wen) begin wen_cnt++; wen_kind = 2; wen_addr = col_map_addr; wen_data = 128'(col_map_wdata); end
    if (ch_t_wen)    begin wen_cnt++; wen_kind = 3; wen_addr = 12'(ch_t_addr); wen_data = ch_t_wdata;       end
    if (arst) lat_cnt = 0;
    else if (psel && penable) lat_cnt++;
    else lat_cnt = 0;
    if (!pready) begin
      checkOutput("prdata_idle_zero", 128'(prdata), 128'h0);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_pready actual=1 expected=0");
    end else begin
      e = exp_q.pop_front();
      checkOutput("prdata", 128'(prdata), 128'(e.rdata));
      checkOutput("pslverr", 128'(pslverr), 128'(e.err));
      checkOutput("latency", 128'(lat_cnt), 128'(e.lat));
      checkOutput("wen_count", 128'(wen_cnt), 128'(e.nwen));
      if (e.nwen == 1) begin
        checkOutput("wen_kind", 128'(wen_kind), 128'(e.kind));
        checkOutput("wen_addr", 128'(wen_addr), 128'(e.waddr));
        checkOutput("wen_data", wen_data, e.wdata);
      end
      wen_cnt = 0; wen_kind = 0; wen_addr = '0; wen_data = '0;
    end
  end

  // Starts at posedge+1 and leaves at posedge+1 so calls can run back-to-back
  task automatic applyStimulus(input logic wr, input logic [15:0] addr,
                               input logic [31:0] data, input exp_t e);
    bit done = 0;
    exp_q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (pready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout addr=%0h actual=no_pready expected=pready", addr);
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checkOutput(name, {44'h0, prdata, pready, pslverr, ch_map_wen, col_map_wen, ch_t_wen,
                       ch_map_addr, col_map_addr, ch_t_addr, ch_map_wdata, col_map_wdata},
                128'h0);
    checkOutput({name, "_glyph"}, ch_t_wdata, 128'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin ch_map_mem[i] = 8'h0; col_map_mem[i] = 8'h0; end
    for (int i = 0; i < 128; i++) ch_t_mem[i] = 128'h0;
    col_map_mem[1]    = 8'h5A;
    ch_map_mem[2399]  = 8'h77;
    ch_t_mem[5]       = 128'h44444444_33333333_22222222_11111111;
    ch_t_mem[7]       = 128'h77777777_66666666_55555555_CAFEF00D;

    arst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;

    // Map write then readback; col_map read
    applyStimulus(1'b1, 16'h0008, 32'h0000_0041, mk(32'h0, 1'b0, 1, 1, 1, 12'd2, 128'h41));
    applyStimulus(1'b0, 16'h0008, 32'h0, mk(32'h41, 1'b0, 2, 0, 0, 12'd0, 128'h0));
    applyStimulus(1'b0, 16'h4004, 32'h0, mk(32'h5A, 1'b0, 2, 0, 0, 12'd0, 128'h0));

    // Glyph read-modify-write into a zero row and into a patterned row
    applyStimulus(1'b1, 16'h8038, 32'hDEADBEEF,
                  mk(32'h0, 1'b0, 3, 1, 3, 12'd3, {32'h0, 32'hDEADBEEF, 64'h0}));
    applyStimulus(1'b0, 16'h8038, 32'h0, mk(32'hDEADBEEF, 1'b0, 3, 0, 0, 12'd0, 128'h0));
    applyStimulus(1'b1, 16'h8050, 32'hAAAA5555,
                  mk(32'h0, 1'b0, 3, 1, 3, 12'd5, 128'h44444444_33333333_22222222_AAAA5555));
    applyStimulus(1'b0, 16'h805C, 32'h0, mk(32'h44444444, 1'b0, 3, 0, 0, 12'd0, 128'h0));
    applyStimulus(1'b0, 16'h8050, 32'h0, mk(32'hAAAA5555, 1'b0, 3, 0, 0, 12'd0, 128'h0));

    // Range boundaries and reserved/misaligned addresses
    applyStimulus(1'b1, 16'h2580, 32'h0000_00FF, mk(32'h0, EXP_ERR, 1, 0, 0, 12'd0, 128'h0));
    applyStimulus(1'b0, 16'h257C, 32'h0, mk(32'h77, 1'b0, 2, 0, 0, 12'd0, 128'h0));
    applyStimulus(1'b1, 16'h6580, 32'h0000_0011, mk(32'h0, EXP_ERR, 1, 0, 0, 12'd0, 128'h0));
    applyStimulus(1'b0, 16'h0009, 32'h0, mk(32'h0, EXP_ERR, 1, 0, 0, 12'd0, 128'h0));
    applyStimulus(1'b0, 16'hC000, 32'h0, mk(32'h0, EXP_ERR, 1, 0, 0, 12'd0, 128'h0));
    applyStimulus(1'b1, 16'h8800, 32'h1234_5678, mk(32'h0, EXP_ERR, 1, 0, 0, 12'd0, 128'h0));

    // Reset asserted in CHT_LATCH of a glyph write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h8070; pwdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    arst = 1'b1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 16'h8070, 32'h0, mk(32'hCAFEF00D, 1'b0, 3, 0, 0, 12'd0, 128'h0));

    // psel dropped during CHT_LATCH: write abandoned
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h8054; pwdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1'b0, 16'h8054, 32'h0, mk(32'h22222222, 1'b0, 3, 0, 0, 12'd0, 128'h0));

    // Back-to-back transfers
    applyStimulus(1'b1, 16'h0010, 32'h1234_56C3, mk(32'h0, 1'b0, 1, 1, 1, 12'd4, 128'hC3));
    applyStimulus(1'b0, 16'h8038, 32'h0, mk(32'hDEADBEEF, 1'b0, 3, 0, 0, 12'd0, 128'h0));
    applyStimulus(1'b0, 16'h0010, 32'h0, mk(32'hC3, 1'b0, 2, 0, 0, 12'd0, 128'h0));
    applyStimulus(1'b0, 16'hC004, 32'h0, mk(32'h0, EXP_ERR, 1, 0, 0, 12'd0, 128'h0));

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_drain", 128'(exp_q.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
